// File: rtl/psum_collector.sv
// psum_collector: segments the free-running MAC accumulator stream into
// tagged dot-product windows and queues each window's partial sum and
// operand count in a small valid/ready FIFO.
module psum_collector #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [WIDTH-1:0] mac_out,
  input  logic                    err_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_psum,
  output logic [CNT_WIDTH-1:0]    out_count,
  output logic                    err_proto,
  output logic                    err_ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam int unsigned EW = WIDTH + CNT_WIDTH;

  typedef enum logic {IDLE, OPEN} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Sanitized tag for the pair presented this cycle
  logic                 tag_first, tag_last;
  logic [CNT_WIDTH-1:0] tag_cnt;
  logic                 proto_set;

  // Tag delay pipe; index 0 is stage 1. The first flag is only consumed
  // at stage 2, so it is carried two stages instead of three.
  logic [1:0]           pf_q;
  logic [2:0]           pl_q;
  logic [CNT_WIDTH-1:0] pc_q [3];

  logic signed [WIDTH-1:0] base_q;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic          push, pop, full, accept, ovf_set;
  logic [EW-1:0] head;
  logic [WIDTH-1:0] psum_new;

  logic err_proto_q, err_ovf_q;

  // Input-stage FSM: window tracking, count and tag sanitization
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    tag_cnt   = cnt_q;
    proto_set = 1'b0;
    if (in_valid) begin
      if (in_first) begin
        tag_first = 1'b1;
        tag_last  = in_last;
        tag_cnt   = CNT_WIDTH'(1);
        cnt_d     = CNT_WIDTH'(1);
        proto_set = (state_q == OPEN);
        state_d   = in_last ? IDLE : OPEN;
      end else if (state_q == OPEN) begin
        tag_cnt  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        cnt_d    = tag_cnt;
        tag_last = in_last;
        if (in_last) state_d = IDLE;
      end else if (in_last) begin
        proto_set = 1'b1;
      end
    end
  end

  // FSM state and window counter registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag pipe and baseline capture aligned to the MAC latency
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pf_q   <= '0;
      pl_q   <= '0;
      pc_q   <= '{default: '0};
      base_q <= '0;
    end else begin
      pf_q    <= {pf_q[0], tag_first};
      pl_q    <= {pl_q[1:0], tag_last};
      pc_q[0] <= tag_cnt;
      pc_q[1] <= pc_q[0];
      pc_q[2] <= pc_q[1];
      if (pf_q[1]) base_q <= mac_out;
    end
  end

  // FIFO control: push on window close, pop on handshake
  always_comb begin
    psum_new = WIDTH'(mac_out - base_q);
    push     = pl_q[2];
    pop      = (fill_q != '0) && out_ready;
    full     = (fill_q == DEPTH_C);
    accept   = push && (!full || pop);
    ovf_set  = push && full && !pop;
    fill_d   = fill_q + (AW+1)'(accept) - (AW+1)'(pop);
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= {psum_new, pc_q[2]};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
    end
  end

  // Sticky error flags; a new violation beats a same-cycle clear
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_proto_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      err_proto_q <= (err_proto_q && !err_clr) || proto_set;
      err_ovf_q   <= (err_ovf_q && !err_clr) || ovf_set;
    end
  end

  // Output mapping; head is masked to zero while empty
  always_comb begin
    head      = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
    out_valid = (fill_q != '0);
    out_psum  = head[EW-1:CNT_WIDTH];
    out_count = head[CNT_WIDTH-1:0];
    err_proto = err_proto_q;
    err_ovf   = err_ovf_q;
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: drives tagged operand windows through a behavioural MAC
// into psum_collector and checks results against per-window expected sums.
module tb_psum_collector;

  logic        clk = 1'b0;
  logic        rstb;
  logic        in_valid, in_first, in_last;
  logic signed [15:0] mac_out;
  logic        err_clr;
  logic        out_valid, out_ready;
  logic [15:0] out_psum_w;
  logic [7:0]  out_count;
  logic        err_proto, err_ovf;

  int total = 0;
  int bad   = 0;

  // Operands and a simple MAC: two register stages then accumulate
  logic signed [15:0] a_r, b_r;
  logic [15:0] p1, p2;

  // Reference: each window's sum of products mod 2^16 and its pair count
  logic [23:0] exp_q [$];
  bit          m_open;
  logic [15:0] m_sum;
  logic [7:0]  m_cnt;

  always #5 clk = ~clk;

  psum_collector #(.WIDTH(16), .CNT_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .mac_out(mac_out), .err_clr(err_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum_w),
    .out_count(out_count), .err_proto(err_proto), .err_ovf(err_ovf)
  );

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p1 <= '0; p2 <= '0; mac_out <= '0;
    end else begin
      p1      <= 16'(a_r * b_r);
      p2      <= p1;
      mac_out <= mac_out + p2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Every accepted head entry must match the oldest expected window
  always @(negedge clk) begin
    if (rstb && out_valid && out_ready) begin
      logic [23:0] e;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL pop_unexpected observed=%0d expected=none", out_psum_w);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_psum", 32'(out_psum_w), 32'(e[23:8]));
        check("pop_count", 32'(out_count), 32'(e[7:0]));
      end
    end
  end

  task automatic drive(input bit v, input bit f, input bit l, input int a, input int b);
    in_valid = v; in_first = f; in_last = l;
    a_r = v ? 16'(a) : 16'sd0;
    b_r = v ? 16'(b) : 16'sd0;
    if (v) begin
      if (f) begin m_open = 1; m_sum = '0; m_cnt = '0; end
      if (m_open) begin
        m_sum = m_sum + 16'(a * b);
        if (m_cnt != 8'hff) m_cnt++;
        if (l) begin exp_q.push_back({m_sum, m_cnt}); m_open = 0; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    m_open = 0;
    exp_q.delete();
    @(posedge clk); #1;
    rstb = 1'b1;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) idle();
    check("drain_valid", 32'(out_valid), 0);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    rstb = 1'b0; in_valid = 0; in_first = 0; in_last = 0;
    a_r = '0; b_r = '0; err_clr = 0; out_ready = 1; m_open = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_psum", 32'(out_psum_w), 0);
    check("rst_count", 32'(out_count), 0);
    check("rst_proto", 32'(err_proto), 0);
    check("rst_ovf", 32'(err_ovf), 0);
    rstb = 1'b1;
    idle();

    // Three-pair window then a first+last window right behind it
    drive(1, 1, 0, 2, 3);
    drive(1, 0, 0, 4, 5);
    drive(1, 0, 1, -1, 6);
    drive(1, 1, 1, 7, 7);
    check("lat_k1", 32'(out_valid), 0);
    idle();
    check("lat_k2", 32'(out_valid), 0);
    idle();
    check("lat_k3", 32'(out_valid), 1);
    check("w1_psum", 32'(out_psum_w), 20);
    check("w1_count", 32'(out_count), 3);
    idle();
    check("w2_psum", 32'(out_psum_w), 49);
    check("w2_count", 32'(out_count), 1);
    wait_empty();

    // Accumulator wrap: preload to 32767, then a (1,1) window
    do_reset();
    drive(1, 1, 0, 181, 181);
    drive(1, 0, 1, 1, 6);
    repeat (4) idle();
    drive(1, 1, 1, 1, 1);
    repeat (3) idle();
    check("wrap_valid", 32'(out_valid), 1);
    check("wrap_psum", 32'(out_psum_w), 1);
    wait_empty();

    // Backpressure: five windows into a four-deep FIFO
    out_ready = 0;
    for (int i = 1; i <= 5; i++) drive(1, 1, 1, i, i);
    repeat (4) idle();
    void'(exp_q.pop_back());
    check("bp_ovf", 32'(err_ovf), 1);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_head", 32'(out_psum_w), 1);
    repeat (3) idle();
    check("bp_hold_psum", 32'(out_psum_w), 1);
    check("bp_hold_count", 32'(out_count), 1);
    out_ready = 1;
    repeat (4) idle();
    check("bp_drained", 32'(out_valid), 0);
    check("bp_left", exp_q.size(), 0);
    err_clr = 1;
    idle();
    err_clr = 0;
    check("ovf_clr", 32'(err_ovf), 0);

    // Protocol: stray last, clear racing a violation, first while open
    drive(1, 0, 1, 0, 0);
    check("proto_stray", 32'(err_proto), 1);
    repeat (4) idle();
    check("proto_nopush", 32'(out_valid), 0);
    err_clr = 1;
    drive(1, 0, 1, 0, 0);
    check("proto_clr_race", 32'(err_proto), 1);
    idle();
    err_clr = 0;
    check("proto_clr", 32'(err_proto), 0);
    drive(1, 1, 0, 2, 2);
    drive(1, 0, 0, 3, 3);
    drive(1, 1, 0, 4, 4);
    check("proto_abort", 32'(err_proto), 1);
    drive(1, 0, 1, 5, 5);
    repeat (3) idle();
    check("abort_valid", 32'(out_valid), 1);
    check("abort_psum", 32'(out_psum_w), 41);
    check("abort_count", 32'(out_count), 2);
    wait_empty();

    // Reset in the middle of an open window
    drive(1, 1, 0, 2, 2);
    drive(1, 0, 0, 3, 3);
    rstb = 0;
    m_open = 0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_psum", 32'(out_psum_w), 0);
    check("mid_rst_count", 32'(out_count), 0);
    check("mid_rst_proto", 32'(err_proto), 0);
    check("mid_rst_ovf", 32'(err_ovf), 0);
    @(posedge clk); #1;
    rstb = 1;
    repeat (5) idle();
    check("mid_rst_nopush", 32'(out_valid), 0);
    drive(1, 1, 1, 3, 3);
    repeat (3) idle();
    check("post_rst_psum", 32'(out_psum_w), 9);
    wait_empty();

    // Randomized well-formed windows with random gaps
    for (int w = 0; w < 30; w++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int p = 0; p < len; p++)
        drive(1, p == 0, p == len - 1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      repeat ($urandom_range(0, 2)) idle();
    end
    wait_empty();
    check("rand_proto", 32'(err_proto), 0);
    check("rand_ovf", 32'(err_ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
